// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD acquisition path: default sample geometry,
// accumulator width derivation and the accumulator state encoding.
package spgd_pkg;

    localparam int SPGD_DATA_W = 14;
    localparam int SPGD_N_LOG2 = 10;

    typedef enum logic [1:0] {
        ACC_IDLE = 2'd0,
        ACC_RUN  = 2'd1,
        ACC_DONE = 2'd2
    } acc_state_t;

    // N samples of DATA_W bits each can grow the sum by at most N_LOG2 bits.
    function automatic int acc_width(input int data_w, input int n_log2);
        return data_w + n_log2;
    endfunction

endpackage

// File: rtl/adc_accumulator.sv
// Block integrator for signed ADC samples: sums 2^N_LOG2 samples, freezes the
// sum behind `done`, and hands it to the sequencer through `metric`.
module adc_accumulator
    import spgd_pkg::*;
#(
    parameter int DATA_W = SPGD_DATA_W,
    parameter int N_LOG2 = SPGD_N_LOG2,
    parameter int ACC_W  = acc_width(DATA_W, N_LOG2)
) (
    input  logic                     adc_clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic signed [DATA_W-1:0] adc_data,
    input  logic                     reg_write,
    input  logic                     adc_rst,
    output logic                     done,
    output logic signed [ACC_W-1:0]  metric,
    output logic                     metric_valid,
    output logic [N_LOG2-1:0]        sample_cnt
);

    localparam logic [N_LOG2-1:0] CNT_LAST = '1;

    acc_state_t              state_reg;
    acc_state_t              state_next;
    logic signed [ACC_W-1:0] acc_reg;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] sample_ext;
    logic [N_LOG2-1:0]       cnt_reg;
    logic [N_LOG2-1:0]       cnt_next;
    logic                    capture;
    logic                    done_next;

    assign sample_ext = {{(ACC_W - DATA_W){adc_data[DATA_W-1]}}, adc_data};

    // Next-state and datapath decisions; enable overrides every strobe.
    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (!enable) begin
            state_next = ACC_IDLE;
            acc_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ACC_IDLE: begin
                    state_next = ACC_RUN;
                    acc_next   = '0;
                    cnt_next   = '0;
                end
                ACC_RUN: begin
                    if (adc_rst) begin
                        acc_next = '0;
                        cnt_next = '0;
                    end else begin
                        acc_next = acc_reg + sample_ext;
                        cnt_next = cnt_reg + 1'b1;
                        if (cnt_reg == CNT_LAST) begin
                            state_next = ACC_DONE;
                        end
                    end
                end
                ACC_DONE: begin
                    // Capture reads acc_reg, so a same-cycle clear still
                    // delivers the finished block sum.
                    capture = reg_write;
                    if (adc_rst) begin
                        state_next = ACC_RUN;
                        acc_next   = '0;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = ACC_IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
        done_next = (state_next == ACC_DONE);
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ACC_IDLE;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done      <= done_next;
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            cnt_reg      <= '0;
            metric       <= '0;
            metric_valid <= 1'b0;
        end else begin
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            metric_valid <= capture;
            if (capture) begin
                metric <= acc_reg;
            end
        end
    end

    assign sample_cnt = cnt_reg;

endmodule

// File: tb/tb_adc_accumulator.sv
// Directed and randomized checks of adc_accumulator with a 4-sample block,
// including a closed loop against a registered sequencer model.
module tb_adc_accumulator;

    localparam int DATA_W = 14;
    localparam int N_LOG2 = 2;
    localparam int ACC_W  = DATA_W + N_LOG2;
    localparam int N      = 1 << N_LOG2;

    logic                     clk;
    logic                     rst_n;
    logic                     enable;
    logic signed [DATA_W-1:0] adc_data;
    logic                     reg_write;
    logic                     adc_rst;
    logic                     done;
    logic signed [ACC_W-1:0]  metric;
    logic                     metric_valid;
    logic [N_LOG2-1:0]        sample_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: sum and count of samples in the current block, and the
    // value the sequencer last captured.
    int blk_sum = 0;
    int blk_cnt = 0;
    int exp_metric = 0;

    adc_accumulator #(
        .DATA_W(DATA_W),
        .N_LOG2(N_LOG2)
    ) dut (
        .adc_clk     (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .adc_data    (adc_data),
        .reg_write   (reg_write),
        .adc_rst     (adc_rst),
        .done        (done),
        .metric      (metric),
        .metric_valid(metric_valid),
        .sample_cnt  (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_sample();
        logic signed [DATA_W-1:0] r;
        r = DATA_W'($urandom);
        return int'(r);
    endfunction

    task automatic clear_model();
        blk_sum = 0;
        blk_cnt = 0;
    endtask

    task automatic feed_one(input int v, input string tag);
        adc_data = DATA_W'(v);
        tick();
        blk_sum += v;
        blk_cnt++;
        check({tag, "_cnt"}, sample_cnt, blk_cnt % N);
        check({tag, "_done"}, done, (blk_cnt == N) ? 1 : 0);
        $display("[TB] %s sample %0d -> cnt %0d done %0d", tag, v, sample_cnt, done);
    endtask

    // Sequencer-style handshake: one reg_write cycle then one adc_rst cycle.
    task automatic capture_and_clear(input string tag);
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        exp_metric = blk_sum;
        check({tag, "_metric"}, metric, exp_metric);
        check({tag, "_mv_hi"}, metric_valid, 1);
        check({tag, "_done_hold"}, done, 1);
        adc_rst = 1'b1;
        tick();
        adc_rst = 1'b0;
        check({tag, "_mv_lo"}, metric_valid, 0);
        check({tag, "_done_clr"}, done, 0);
        check({tag, "_cnt_clr"}, sample_cnt, 0);
        $display("[TB] %s capture metric %0d", tag, metric);
        clear_model();
    endtask

    int seq;
    int ramp;
    int cyc;
    int last_rise;
    int rises;
    int blocks;
    int mv_seen;
    int prev_done;
    int garbage;

    initial begin
        rst_n     = 1'b1;
        enable    = 1'b0;
        adc_data  = '0;
        reg_write = 1'b0;
        adc_rst   = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_done", done, 0);
        check("rst_metric", metric, 0);
        check("rst_mv", metric_valid, 0);
        check("rst_cnt", sample_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Constant 100: done after exactly N accumulate edges.
        enable = 1'b1;
        adc_data = DATA_W'(100);
        tick();
        check("c100_leave_idle", done, 0);
        clear_model();
        for (int i = 0; i < N; i++) feed_one(100, "c100");
        for (int i = 0; i < 3; i++) begin
            adc_data = DATA_W'(rand_sample());
            tick();
            check("c100_frozen_done", done, 1);
        end
        capture_and_clear("c100");
        check("c100_value", exp_metric, 400);

        // Full-scale negative then positive blocks.
        for (int i = 0; i < N; i++) feed_one(-8192, "neg");
        capture_and_clear("neg");
        check("neg_value", metric, -32768);
        for (int i = 0; i < N; i++) feed_one(8191, "pos");
        capture_and_clear("pos");
        check("pos_value", metric, 32764);

        // Simultaneous reg_write and adc_rst in DONE.
        for (int i = 0; i < N; i++) feed_one(100, "both");
        reg_write = 1'b1;
        adc_rst = 1'b1;
        tick();
        reg_write = 1'b0;
        adc_rst = 1'b0;
        exp_metric = 400;
        check("both_metric", metric, exp_metric);
        check("both_mv", metric_valid, 1);
        check("both_done", done, 0);
        check("both_cnt", sample_cnt, 0);
        clear_model();
        for (int i = 0; i < N; i++) feed_one(rand_sample(), "after_both");
        capture_and_clear("after_both");

        // enable dropped at count 2; strobes in IDLE have no effect.
        feed_one(rand_sample(), "drop");
        feed_one(rand_sample(), "drop");
        enable = 1'b0;
        tick();
        check("drop_cnt", sample_cnt, 0);
        check("drop_done", done, 0);
        check("drop_metric", metric, exp_metric);
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        check("idle_wr_metric", metric, exp_metric);
        check("idle_wr_mv", metric_valid, 0);
        adc_rst = 1'b1;
        tick();
        adc_rst = 1'b0;
        check("idle_rst_cnt", sample_cnt, 0);
        clear_model();
        enable = 1'b1;
        tick();
        check("reen_done", done, 0);
        for (int i = 0; i < N; i++) feed_one(rand_sample(), "reen");
        capture_and_clear("reen");

        // adc_rst mid-block restarts the block.
        feed_one(rand_sample(), "midrst");
        feed_one(rand_sample(), "midrst");
        adc_rst = 1'b1;
        tick();
        adc_rst = 1'b0;
        check("midrst_cnt", sample_cnt, 0);
        check("midrst_done", done, 0);
        clear_model();
        for (int i = 0; i < N; i++) feed_one(rand_sample(), "midrst_blk");
        capture_and_clear("midrst_blk");

        // Asynchronous reset between edges.
        feed_one(rand_sample(), "arst");
        feed_one(rand_sample(), "arst");
        #3 rst_n = 1'b0;
        #1;
        check("arst_metric", metric, 0);
        check("arst_cnt", sample_cnt, 0);
        check("arst_done", done, 0);
        check("arst_mv", metric_valid, 0);
        exp_metric = 0;
        clear_model();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("arst_leave_idle", sample_cnt, 0);
        feed_one(rand_sample(), "accwr");
        reg_write = 1'b1;
        feed_one(rand_sample(), "accwr");
        reg_write = 1'b0;
        check("accwr_metric", metric, exp_metric);
        check("accwr_mv", metric_valid, 0);
        feed_one(rand_sample(), "accwr");
        feed_one(rand_sample(), "accwr");
        capture_and_clear("accwr");

        // Random blocks with a random dwell in DONE before capture.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) feed_one(rand_sample(), "rnd");
            garbage = int'($urandom_range(0, 3));
            for (int g = 0; g < garbage; g++) begin
                adc_data = DATA_W'(rand_sample());
                tick();
                check("rnd_dwell_done", done, 1);
                check("rnd_dwell_cnt", sample_cnt, 0);
            end
            capture_and_clear("rnd");
        end

        // Closed loop against a registered sequencer, ramp 0..3 per block.
        seq = 0;
        ramp = 1;
        cyc = 0;
        last_rise = -1;
        rises = 0;
        blocks = 0;
        mv_seen = 0;
        prev_done = 0;
        adc_data = '0;
        while (blocks < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (metric_valid) mv_seen++;
            if (done && prev_done == 0) begin
                if (last_rise >= 0) check("cl_period", cyc - last_rise, N + 3);
                last_rise = cyc;
                rises++;
            end
            prev_done = done ? 1 : 0;
            case (seq)
                0: begin
                    if (done) seq = 1;
                    else begin
                        adc_data = DATA_W'(ramp % 4);
                        ramp++;
                    end
                end
                1: begin
                    reg_write = 1'b1;
                    seq = 2;
                end
                2: begin
                    check("cl_metric", metric, 6);
                    check("cl_mv", metric_valid, 1);
                    $display("[TB] closed-loop block %0d metric %0d at cycle %0d", blocks, metric, cyc);
                    reg_write = 1'b0;
                    adc_rst = 1'b1;
                    blocks++;
                    seq = 3;
                end
                default: begin
                    check("cl_done_low", done, 0);
                    adc_rst = 1'b0;
                    adc_data = '0;
                    ramp = 1;
                    seq = 0;
                end
            endcase
        end
        check("cl_blocks", blocks, 10);
        check("cl_rises", rises, 10);
        check("cl_mv_count", mv_seen, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_accumulator.md
# adc_accumulator

Sample-side responder to the SPGD acquisition sequencer. Integrates a fixed block of signed ADC samples on `adc_clk`, then raises `done` and holds the frozen sum until the sequencer strobes `reg_write` to capture it into `metric` and `adc_rst` to clear the accumulator and start the next block. Sits between the ADC input register and the sequencer. Its `metric` output feeds the SPGD gradient/register logic.

## Interface
Parameters:
- `DATA_W`, 14, ADC sample width (signed, two's complement)
- `N_LOG2`, 10, log2 of samples per block (N = 2^N_LOG2)
- `ACC_W`, DATA_W+N_LOG2, accumulator/metric width (overflow-free by construction)

Ports:
- `adc_clk` in 1: single clock, all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: run control; low forces IDLE
- `adc_data` in DATA_W: signed sample, valid every cycle
- `reg_write` in 1: capture strobe from sequencer
- `adc_rst` in 1: clear/restart strobe from sequencer
- `done` out 1: block complete, sum frozen
- `metric` out ACC_W: last captured block sum (signed)
- `metric_valid` out 1: one-cycle pulse when `metric` updates
- `sample_cnt` out N_LOG2: samples accumulated in current block

## Operation
- States: IDLE, ACCUM, DONE. Encodings are in the shared package.
- Reset (`rst_n`=0): state IDLE, acc=0, count=0, `done`=0, `metric`=0, `metric_valid`=0, `sample_cnt`=0.
- IDLE: acc and count held at 0. `enable`=1 moves to ACCUM on the next edge.
- ACCUM: each edge does acc += sign-extend(`adc_data`) and count += 1. On the edge where count==N-1, the Nth sample is added, state becomes DONE and `done`=1. The count wraps to 0.
- DONE: acc frozen, `adc_data` ignored, `done` held high.
  - `reg_write`=1 → `metric` <= acc and `metric_valid` pulses for 1 cycle.
  - `adc_rst`=1 → acc=0, count=0, `done`=0, state ACCUM. The first sample of the new block is added on the following edge.
- `reg_write` outside DONE: ignored, `metric` unchanged.
- `adc_rst` in ACCUM: acc and count cleared, stays in ACCUM, the block restarts. `adc_rst` in IDLE: no effect.
- `reg_write` and `adc_rst` in the same cycle while in DONE: capture the pre-clear acc into `metric`, then clear. Both take effect on the same edge.
- `enable` low in any state: next edge gives IDLE, acc/count cleared, `done`=0. `metric` retained.
- `enable` has priority over `adc_rst` and `reg_write`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `done` rises on the N-th ACCUM edge after leaving IDLE or after `adc_rst`.
- `done` falls on the edge that samples `adc_rst`=1.
- Sequencer compatibility:
  - Sequencer sees `done` and issues `reg_write` (1 cycle), then `adc_rst` (1 cycle), then returns to waiting.
  - `done` is already low when the sequencer next samples it, so there is no double trigger.
- `metric`/`metric_valid` update on the edge sampling `reg_write`.
- Block period under that sequencer: N + 3 cycles (N accumulate, plus detect, plus write, plus reset).
- Arithmetic: signed; sign-extend to ACC_W before adding. Max |sum| = N·2^(DATA_W-1), which fits ACC_W with no saturation logic.

## Structure
- Shared package `spgd_pkg` holds:
  - state encoding constants `ACC_IDLE`, `ACC_RUN`, `ACC_DONE`
  - default `DATA_W` and `N_LOG2`
  - the ACC_W derivation
- No sub-module. The sign-extending adder and counter are inline in a single module, with one state register block and one datapath block.

## Test plan
- N_LOG2=2, `adc_data`=100 constant, `enable`=1 → `done` rises 4 cycles after enable edge. `reg_write` → `metric`=400 and 1-cycle `metric_valid`. `adc_rst` → `done`=0 next edge.
- N_LOG2=2, `adc_data`=-8192 constant → `metric`=-32768 (16-bit, 0x8000). Then +8191 constant → `metric`=32764.
- Assert `reg_write`+`adc_rst` together in DONE with acc=400 → `metric`=400, acc=0, `done`=0 on the same edge. The next block accumulates from 0.
- Drop `enable` mid-block at count=2 → IDLE next edge, `sample_cnt`=0, `done`=0, `metric` unchanged. Re-enable → full N-sample block.
- Assert `rst_n` low asynchronously mid-ACCUM (between edges) → all outputs 0 immediately. Pulse `reg_write` in ACCUM → `metric` unchanged, no `metric_valid`.
- Closed loop with sequencer model for 10 blocks, ramp `adc_data` 0..3 repeating → `metric`=6 each block, period N+3 cycles, no missed or duplicated `done`.
